snn_lif_layer: RTL and testbench

Parametrised successor of the fixed 8-in/2-out SNN top. It provides N_IN rate-coding encoder neurons driven by multi-bit input values, and a fully connected layer of N_OUT leaky integrate-and-fire (LIF) output neurons. The layer uses run-time programmable signed weights, a programmable threshold, leak and a refractory period. It replaces the dummy AND-based output logic and sits directly between the input pins and the output spike pins.

---
 rtl/snn_pkg.sv | 44 ++++
 rtl/lif_neuron.sv | 69 ++++++
 rtl/snn_lif_layer.sv | 93 +++++++++
 tb/tb_snn_lif_layer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants and helpers for the snn_lif_layer spiking layer.
// Elaboration-time and combinational helpers only; no state, no flow control.
package snn_pkg;

    localparam int N_IN_DEF       = 8;
    localparam int N_OUT_DEF      = 2;
    localparam int VAL_W_DEF      = 4;
    localparam int W_W_DEF        = 4;
    localparam int POT_W_DEF      = 10;
    localparam int LEAK_SHIFT_DEF = 3;
    localparam int REFRAC_DEF     = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < value) result = k + 1;
        end
        return result;
    endfunction

    // Vector widths must never collapse to zero bits.
    function automatic int min1_clog2(input int value);
        int result;
        result = clog2(value);
        return (result < 1) ? 1 : result;
    endfunction

    function automatic int widx(input int j, input int i, input int n_in);
        return j * n_in + i;
    endfunction

    function automatic logic signed [31:0] clamp_pot(input logic signed [31:0] x,
                                                     input int                 pot_w);
        logic signed [31:0] hi;
        logic signed [31:0] result;
        hi = (32'sd1 <<< (pot_w - 1)) - 32'sd1;
        if (x < 0)       result = '0;
        else if (x > hi) result = hi;
        else             result = x;
        return result;
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: leak, integrate, clamp, fire, refractory.
// Spike registered on the same edge the potential updates; en gates all state, no backpressure.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int POT_W      = POT_W_DEF,
    parameter int SUM_W      = POT_W_DEF + 3,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int REFRAC     = REFRAC_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_i,
    input  logic signed [SUM_W-1:0] syn_sum_i,
    input  logic [POT_W-2:0]        threshold_i,
    output logic                    spike_o
);

    localparam int              R_W      = min1_clog2(REFRAC + 1);
    localparam int              WIDE_W   = SUM_W + 2;
    localparam logic [R_W-1:0]  REFRAC_R = R_W'(REFRAC);

    logic signed [POT_W-1:0]  v_q, v_d;
    logic [R_W-1:0]           r_q, r_d;
    logic                     spike_q, spike_d;
    logic signed [POT_W-1:0]  leak;
    logic signed [WIDE_W-1:0] v_wide;
    logic signed [31:0]       v_clamped;
    logic                     fire;

    assign leak      = v_q >>> LEAK_SHIFT;
    assign v_wide    = WIDE_W'(v_q) - WIDE_W'(leak) + WIDE_W'(syn_sum_i);
    assign v_clamped = clamp_pot(32'(v_wide), POT_W);
    // A zero threshold disables firing while still letting the potential integrate.
    assign fire      = (threshold_i != '0) && (v_clamped >= $signed(32'(threshold_i)));

    always_comb begin
        v_d     = v_q;
        r_d     = r_q;
        spike_d = 1'b0;
        if (en_i) begin
            if (r_q != '0) begin
                r_d = r_q - R_W'(1);
                v_d = '0;
            end else if (fire) begin
                spike_d = 1'b1;
                v_d     = '0;
                r_d     = REFRAC_R;
            end else begin
                v_d = v_clamped[POT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q     <= '0;
            r_q     <= '0;
            spike_q <= 1'b0;
        end else begin
            v_q     <= v_d;
            r_q     <= r_d;
            spike_q <= spike_d;
        end
    end

    assign spike_o = spike_q;

endmodule

// File: rtl/snn_lif_layer.sv
// Rate-coding encoders feeding a fully connected layer of LIF neurons with programmable weights.
// Value change to output spike in 2 edges; en gates all neuron state, weight writes are never stalled.
module snn_lif_layer
    import snn_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int N_OUT      = N_OUT_DEF,
    parameter int VAL_W      = VAL_W_DEF,
    parameter int W_W        = W_W_DEF,
    parameter int POT_W      = POT_W_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int REFRAC     = REFRAC_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  en,
    input  logic [N_IN*VAL_W-1:0]                 inputValue,
    input  logic [POT_W-2:0]                      threshold,
    input  logic                                  wt_we,
    input  logic [min1_clog2(N_IN*N_OUT)-1:0]     wt_addr,
    input  logic [W_W-1:0]                        wt_data,
    output logic [N_IN-1:0]                       input_spikes,
    output logic [N_OUT-1:0]                      output_spikes
);

    localparam int               N_W    = N_IN * N_OUT;
    localparam int               ADDR_W = min1_clog2(N_W);
    localparam int               SUM_W  = POT_W + clog2(N_IN);
    localparam logic [ADDR_W:0]  N_W_L  = (ADDR_W + 1)'(N_W);

    logic [W_W-1:0]          w_q [N_W];
    logic signed [SUM_W-1:0] syn_sum [N_OUT];

    for (genvar i = 0; i < N_IN; i++) begin : g_enc
        logic [VAL_W-1:0] acc_q;
        logic [VAL_W:0]   acc_sum;
        logic             spike_q;

        // The carry out of the phase accumulator is the spike.
        assign acc_sum = {1'b0, acc_q} + {1'b0, inputValue[i*VAL_W +: VAL_W]};

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                acc_q   <= '0;
                spike_q <= 1'b0;
            end else if (en) begin
                acc_q   <= acc_sum[VAL_W-1:0];
                spike_q <= acc_sum[VAL_W];
            end else begin
                spike_q <= 1'b0;
            end
        end

        assign input_spikes[i] = spike_q;
    end

    // Out-of-range addresses are dropped rather than aliased onto a real weight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_W; k++) w_q[k] <= '0;
        end else if (wt_we && ({1'b0, wt_addr} < N_W_L)) begin
            w_q[wt_addr] <= wt_data;
        end
    end

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            syn_sum[j] = '0;
            for (int i = 0; i < N_IN; i++) begin
                if (input_spikes[i]) begin
                    syn_sum[j] = syn_sum[j] + SUM_W'($signed(w_q[widx(j, i, N_IN)]));
                end
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lif
        lif_neuron #(
            .POT_W      (POT_W),
            .SUM_W      (SUM_W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRAC     (REFRAC)
        ) u_lif (
            .clk         (clk),
            .reset       (reset),
            .en_i        (en),
            .syn_sum_i   (syn_sum[j]),
            .threshold_i (threshold),
            .spike_o     (output_spikes[j])
        );
    end

endmodule

// File: tb/tb_snn_lif_layer.sv
// Bench for snn_lif_layer against an arithmetic reference model of encoders, weights and LIF neurons.
// Three output neurons are used so that addresses past the weight table are representable.
module tb_snn_lif_layer;

    localparam int N_IN       = 8;
    localparam int N_OUT      = 3;
    localparam int VAL_W      = 4;
    localparam int W_W        = 4;
    localparam int POT_W      = 10;
    localparam int LEAK_SHIFT = 3;
    localparam int REFRAC     = 2;
    localparam int AW         = 5;
    localparam int V_MAX      = (1 << (POT_W - 1)) - 1;

    logic                  clk;
    logic                  reset;
    logic                  en;
    logic [N_IN*VAL_W-1:0] inputValue;
    logic [POT_W-2:0]      threshold;
    logic                  wt_we;
    logic [AW-1:0]         wt_addr;
    logic [W_W-1:0]        wt_data;
    logic [N_IN-1:0]       input_spikes;
    logic [N_OUT-1:0]      output_spikes;

    int checks = 0;
    int errors = 0;

    int m_acc [N_IN];
    int m_spk [N_IN];
    int m_v   [N_OUT];
    int m_r   [N_OUT];
    int m_out [N_OUT];
    int m_w   [N_IN*N_OUT];

    snn_lif_layer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .VAL_W(VAL_W), .W_W(W_W),
        .POT_W(POT_W), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .inputValue    (inputValue),
        .threshold     (threshold),
        .wt_we         (wt_we),
        .wt_addr       (wt_addr),
        .wt_data       (wt_data),
        .input_spikes  (input_spikes),
        .output_spikes (output_spikes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    function automatic void model_clear();
        for (int i = 0; i < N_IN; i++) begin m_acc[i] = 0; m_spk[i] = 0; end
        for (int j = 0; j < N_OUT; j++) begin m_v[j] = 0; m_r[j] = 0; m_out[j] = 0; end
        for (int k = 0; k < N_IN*N_OUT; k++) m_w[k] = 0;
    endfunction

    // One clock edge of the specified behaviour, using the pre-edge state throughout.
    function automatic void model_step();
        int s, vn, t, thr;
        thr = int'(threshold);
        if (en) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (m_r[j] > 0) begin
                    m_r[j]--; m_v[j] = 0; m_out[j] = 0;
                end else begin
                    s = 0;
                    for (int i = 0; i < N_IN; i++) if (m_spk[i] != 0) s += m_w[j*N_IN + i];
                    vn = m_v[j] - m_v[j] / (2**LEAK_SHIFT) + s;
                    if (vn < 0) vn = 0;
                    if (vn > V_MAX) vn = V_MAX;
                    if (thr != 0 && vn >= thr) begin
                        m_out[j] = 1; m_v[j] = 0; m_r[j] = REFRAC;
                    end else begin
                        m_v[j] = vn; m_out[j] = 0;
                    end
                end
            end
            for (int i = 0; i < N_IN; i++) begin
                t = m_acc[i] + int'(inputValue[i*VAL_W +: VAL_W]);
                m_spk[i] = (t >= 2**VAL_W) ? 1 : 0;
                m_acc[i] = t % (2**VAL_W);
            end
        end else begin
            for (int i = 0; i < N_IN; i++) m_spk[i] = 0;
            for (int j = 0; j < N_OUT; j++) m_out[j] = 0;
        end
        if (wt_we && int'(wt_addr) < N_IN*N_OUT) m_w[wt_addr] = int'($signed(wt_data));
    endfunction

    function automatic logic [N_IN-1:0] exp_in();
        logic [N_IN-1:0] r;
        for (int i = 0; i < N_IN; i++) r[i] = (m_spk[i] != 0);
        return r;
    endfunction

    function automatic logic [N_OUT-1:0] exp_out();
        logic [N_OUT-1:0] r;
        for (int j = 0; j < N_OUT; j++) r[j] = (m_out[j] != 0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_val(input int i, input int v);
        inputValue[i*VAL_W +: VAL_W] = VAL_W'(v);
    endtask

    task automatic write_weight(input int addr, input int data);
        wt_we = 1'b1; wt_addr = AW'(addr); wt_data = W_W'(data);
        tick();
        wt_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b0; wt_we = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; inputValue = $urandom;
        threshold = (POT_W-1)'($urandom_range(1, V_MAX));
        wt_we = 1'b1; wt_addr = AW'($urandom_range(0, 23)); wt_data = W_W'($urandom);
        model_clear();
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checks++;
            if (input_spikes !== '0) begin errors++; $display("FAIL reset_in: input_spikes=%b expected 0", input_spikes); end
            checks++;
            if (output_spikes !== '0) begin errors++; $display("FAIL reset_out: output_spikes=%b expected 0", output_spikes); end
        end
        wt_we = 1'b0; en = 1'b0; reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (input_spikes !== '0 || output_spikes !== '0) begin
                errors++; $display("FAIL idle_en0: in=%b out=%b expected 0/0", input_spikes, output_spikes);
            end
        end
        en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            inputValue = $urandom;
            tick();
            checks++;
            if (input_spikes !== exp_in()) begin errors++; $display("FAIL idle_in edge %0d: got %b expected %b", n, input_spikes, exp_in()); end
            checks++;
            if (output_spikes !== '0) begin errors++; $display("FAIL zero_weights edge %0d: output_spikes=%b expected 0", n, output_spikes); end
        end
    endtask

    task automatic test_encoder_rate();
        int q0[$];
        int exp_edges[4];
        int cnt1, cnt2;
        exp_edges = '{4, 8, 12, 16};
        cnt1 = 0; cnt2 = 0;
        do_reset();
        inputValue = $urandom;
        set_val(0, 4); set_val(1, 0); set_val(2, 15);
        en = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            checks++;
            if (input_spikes !== exp_in()) begin errors++; $display("FAIL enc_model edge %0d: got %b expected %b", n, input_spikes, exp_in()); end
            if (input_spikes[0]) q0.push_back(n);
            if (input_spikes[1]) cnt1++;
            if (input_spikes[2]) cnt2++;
        end
        checks++;
        if (q0.size() != 4) begin
            errors++; $display("FAIL enc_val4_count: got %0d spikes expected 4", q0.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (q0[k] != exp_edges[k]) begin errors++; $display("FAIL enc_val4_edge%0d: got %0d expected %0d", k, q0[k], exp_edges[k]); end
            end
        end
        checks++;
        if (cnt1 != 0) begin errors++; $display("FAIL enc_val0: got %0d spikes expected 0", cnt1); end
        checks++;
        if (cnt2 != 15) begin errors++; $display("FAIL enc_val15: got %0d spikes expected 15", cnt2); end
    endtask

    task automatic run_fire_scenario(output int first, output int second);
        int q[$];
        threshold = 20; inputValue = '0; set_val(0, 15); en = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            checks++;
            if (output_spikes !== exp_out() || input_spikes !== exp_in()) begin
                errors++; $display("FAIL fire_model edge %0d: out=%b in=%b expected out=%b in=%b",
                                   n, output_spikes, input_spikes, exp_out(), exp_in());
            end
            if (output_spikes[0]) q.push_back(n);
        end
        first  = (q.size() > 0) ? q[0] : -1;
        second = (q.size() > 1) ? q[1] : -1;
    endtask

    task automatic test_integrate_fire();
        int first, second;
        do_reset();
        write_weight(0, 7);
        run_fire_scenario(first, second);
        checks++;
        if (first != 5) begin errors++; $display("FAIL fire_first: spike at edge %0d expected 5", first); end
        checks++;
        if (second != 10) begin errors++; $display("FAIL fire_refrac: second spike at edge %0d expected 10", second); end
    endtask

    task automatic test_leak_clamp();
        int spk1;
        do_reset();
        write_weight(8, 7);
        threshold = 511; inputValue = '0; set_val(0, 15); en = 1'b1;
        spk1 = 0;
        for (int n = 0; n < 100; n++) begin
            if (n == 80) threshold = 57;
            tick();
            checks++;
            if (output_spikes !== exp_out()) begin errors++; $display("FAIL leak_model edge %0d: got %b expected %b", n, output_spikes, exp_out()); end
            if (output_spikes[1]) spk1++;
        end
        checks++;
        if (spk1 != 0) begin errors++; $display("FAIL leak_equilibrium: got %0d spikes expected 0", spk1); end
        threshold = 50; spk1 = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if (output_spikes !== exp_out()) begin errors++; $display("FAIL leak_thr50 edge %0d: got %b expected %b", n, output_spikes, exp_out()); end
            if (output_spikes[1]) spk1++;
        end
        checks++;
        if (spk1 == 0) begin errors++; $display("FAIL leak_level: got 0 spikes at threshold 50 expected at least 1"); end
        threshold = 0;
        write_weight(8, -8);
        for (int n = 0; n < 30; n++) tick();
        threshold = 1; spk1 = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            checks++;
            if (output_spikes !== exp_out()) begin errors++; $display("FAIL clamp_model edge %0d: got %b expected %b", n, output_spikes, exp_out()); end
            if (output_spikes[1]) spk1++;
        end
        checks++;
        if (spk1 != 0) begin errors++; $display("FAIL clamp_negative: got %0d spikes expected 0", spk1); end
    endtask

    task automatic test_weight_write();
        int guard, cnt2;
        logic prev;
        do_reset();
        threshold = 1; inputValue = '0; set_val(0, 15); en = 1'b1;
        write_weight(24, 7);
        write_weight(31, 7);
        for (int n = 0; n < 16; n++) begin
            tick();
            checks++;
            if (output_spikes !== '0) begin errors++; $display("FAIL addr_range edge %0d: output_spikes=%b expected 0", n, output_spikes); end
        end
        guard = 0;
        while (!input_spikes[0] && guard < 20) begin tick(); guard++; end
        checks++;
        if (!input_spikes[0]) begin errors++; $display("FAIL wait_spike: input_spikes[0]=0 expected 1 within 20 edges"); end
        write_weight(0, 7);
        checks++;
        if (output_spikes[0] !== 1'b0) begin errors++; $display("FAIL write_coincident: output_spikes[0]=%b expected 0", output_spikes[0]); end
        prev = input_spikes[0];
        tick();
        checks++;
        if (output_spikes[0] !== prev) begin errors++; $display("FAIL write_next_edge: output_spikes[0]=%b expected %b", output_spikes[0], prev); end
        en = 1'b0;
        write_weight(17, 5);
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++;
            if (output_spikes !== '0 || input_spikes !== '0) begin
                errors++; $display("FAIL en0_outputs: out=%b in=%b expected 0/0", output_spikes, input_spikes);
            end
        end
        threshold = 5; set_val(1, 15); en = 1'b1; cnt2 = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if (output_spikes !== exp_out()) begin errors++; $display("FAIL retain_model edge %0d: got %b expected %b", n, output_spikes, exp_out()); end
            if (output_spikes[2]) cnt2++;
        end
        checks++;
        if (cnt2 == 0) begin errors++; $display("FAIL write_en0_retained: neuron 2 got 0 spikes expected at least 1"); end
    endtask

    task automatic test_reset_mid();
        int first, second, spk;
        do_reset();
        write_weight(0, 7);
        threshold = 20; inputValue = '0; set_val(0, 15); en = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        checks++;
        if (output_spikes[0] !== 1'b1) begin errors++; $display("FAIL mid_prespike: output_spikes[0]=%b expected 1", output_spikes[0]); end
        #2 reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (output_spikes !== '0 || input_spikes !== '0) begin
            errors++; $display("FAIL async_reset: out=%b in=%b expected 0/0", output_spikes, input_spikes);
        end
        en = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        write_weight(0, 7);
        run_fire_scenario(first, second);
        checks++;
        if (first != 5 || second != 10) begin
            errors++; $display("FAIL reset_repeat: spikes at %0d,%0d expected 5,10", first, second);
        end
        do_reset();
        threshold = 20; inputValue = '0; set_val(0, 15); en = 1'b1; spk = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (output_spikes != '0) spk++;
        end
        checks++;
        if (spk != 0) begin errors++; $display("FAIL reset_clears_weights: got %0d spiking edges expected 0", spk); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 3) != 0);
            inputValue = $urandom;
            if ($urandom_range(0, 9) == 0) threshold = '0;
            else threshold = (POT_W-1)'($urandom_range(1, 40));
            wt_we = ($urandom_range(0, 9) < 3);
            wt_addr = AW'($urandom_range(0, 31));
            wt_data = W_W'($urandom);
            tick();
            checks++;
            if (input_spikes !== exp_in()) begin errors++; $display("FAIL rand_in cycle %0d: got %b expected %b", n, input_spikes, exp_in()); end
            checks++;
            if (output_spikes !== exp_out()) begin errors++; $display("FAIL rand_out cycle %0d: got %b expected %b", n, output_spikes, exp_out()); end
        end
        wt_we = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; inputValue = '0; threshold = '0;
        wt_we = 1'b0; wt_addr = '0; wt_data = '0;
        model_clear();
        #3;
        test_reset();
        test_encoder_rate();
        test_integrate_fire();
        test_leak_clamp();
        test_weight_write();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
